// File: rtl/pixel_pkg.sv
// Purpose : shared types and constants for the 2x2 pixel readout capture path.
// Latency : n/a (types, constants and a helper function only).
// Backpr. : n/a.
// Contents: state_t (capture FSM encoding), err_t (sticky error codes),
//           NUM_PIX / NUM_COL frame geometry, is_last() index helper.
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW1   = 2'd1,
    ROW2   = 2'd2,
    STREAM = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PROTO = 2'd1,
    ERR_OVR   = 2'd2,
    ERR_ABORT = 2'd3
  } err_t;

  localparam int NUM_PIX = 4;
  localparam int NUM_COL = 2;

  // True for the final pixel index of a frame.
  function automatic logic is_last(input logic [1:0] idx);
    return idx == 2'(NUM_PIX - 1);
  endfunction

endpackage

// File: rtl/pixel_readout_capture_if.sv
// Purpose : valid/ready pixel stream from the capture block to the frame sink.
// Latency : n/a (wiring only).
// Backpr. : sink drops Out_ready; source holds data/addr/last while stalled.
// Ports   : Out_data (PIX_W), Out_addr {row,col}, Out_valid, Out_last (master out),
//           Out_ready (slave out).
interface pixel_readout_capture_if #(
  parameter int PIX_W = 8
) ();

  logic [PIX_W-1:0] Out_data;
  logic [1:0]       Out_addr;
  logic             Out_valid;
  logic             Out_ready;
  logic             Out_last;

  modport master (
    output Out_data,
    output Out_addr,
    output Out_valid,
    output Out_last,
    input  Out_ready
  );

  modport slave (
    input  Out_data,
    input  Out_addr,
    input  Out_valid,
    input  Out_last,
    output Out_ready
  );

endinterface

// File: rtl/edge_detect.sv
// Purpose : one-flop edge detector, rise/fall flags relative to previous cycle.
// Latency : flags are combinational from the live input (0 cycles).
// Backpr. : none.
// Ports   : Clk, Reset (async active-low), d in; q registered copy; rise, fall out.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/pixel_readout_capture.sv
// Purpose : capture a 2x2 pixel frame from ADC strobes, then stream it out.
// Latency : Col_data captured on the adc_rise edge; Out_valid one cycle after
//           the row-2 close (NRE_2 fall or Erase); 1 pixel/cycle when ready.
// Backpr. : Out_data/Out_addr/Out_last held while Out_valid & ~Out_ready;
//           ADC strobes arriving while streaming are dropped as overrun.
// Ports   : Clk, Reset (async active-low), NRE_1, NRE_2, ADC, Expose, Erase,
//           Col_data {col1,col0}; out_if (master stream); Busy; Err (sticky code).
module pixel_readout_capture
  import pixel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     NRE_1,
  input  logic                     NRE_2,
  input  logic                     ADC,
  input  logic                     Expose,
  input  logic                     Erase,
  input  logic [NUM_COL*PIX_W-1:0] Col_data,
  pixel_readout_capture_if.master  out_if,
  output logic                     Busy,
  output logic [1:0]               Err
);

  logic adc_q, adc_rise, adc_fall_unused;
  logic nre2_q, nre2_rise_unused, nre2_fall;
  logic exp_q, exp_rise, exp_fall_unused;

  edge_detect u_adc_edge (
    .Clk  (Clk),
    .Reset(Reset),
    .d    (ADC),
    .q    (adc_q),
    .rise (adc_rise),
    .fall (adc_fall_unused)
  );

  edge_detect u_nre2_edge (
    .Clk  (Clk),
    .Reset(Reset),
    .d    (NRE_2),
    .q    (nre2_q),
    .rise (nre2_rise_unused),
    .fall (nre2_fall)
  );

  edge_detect u_exp_edge (
    .Clk  (Clk),
    .Reset(Reset),
    .d    (Expose),
    .q    (exp_q),
    .rise (exp_rise),
    .fall (exp_fall_unused)
  );

  logic [PIX_W-1:0] col0, col1;
  assign col0 = Col_data[PIX_W-1:0];
  assign col1 = Col_data[NUM_COL*PIX_W-1:PIX_W];

  state_t           state;
  err_t             err_q;
  logic [PIX_W-1:0] pix [NUM_PIX];
  logic [1:0]       idx;
  logic [PIX_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      err_q       <= ERR_NONE;
      idx         <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < NUM_PIX; i++) begin
        pix[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (adc_rise) begin
            if (NRE_1 && !NRE_2) begin
              pix[0] <= col0;
              pix[1] <= col1;
              state  <= ROW1;
            end else begin
              err_q <= ERR_PROTO;
            end
          end else if (exp_rise) begin
            // A new exposure clears the sticky error unless an error lands
            // on the same cycle.
            err_q <= ERR_NONE;
          end
        end

        ROW1: begin
          if (exp_rise) begin
            err_q <= ERR_ABORT;
            state <= IDLE;
          end else if (adc_rise) begin
            if (NRE_2 && !NRE_1) begin
              pix[2] <= col0;
              pix[3] <= col1;
              state  <= ROW2;
            end else if (NRE_1 && !NRE_2) begin
              // Repeated row-0 conversion: latest sample replaces the old one.
              pix[0] <= col0;
              pix[1] <= col1;
            end else begin
              err_q <= ERR_PROTO;
              state <= IDLE;
            end
          end
        end

        ROW2: begin
          if (exp_rise) begin
            err_q <= ERR_ABORT;
            state <= IDLE;
          end else if (adc_rise && nre2_fall) begin
            // ADC must not pulse while the row enable is dropping.
            err_q <= ERR_PROTO;
            state <= IDLE;
          end else if (adc_rise && NRE_2) begin
            pix[2] <= col0;
            pix[3] <= col1;
          end else if (adc_rise) begin
            err_q <= ERR_PROTO;
            state <= IDLE;
          end else if (nre2_fall || Erase) begin
            state       <= STREAM;
            idx         <= 2'd0;
            out_data_q  <= pix[0];
            out_valid_q <= 1'b1;
            out_last_q  <= is_last(2'd0);
          end
        end

        STREAM: begin
          // The captured frame always drains; new conversions are only flagged.
          if (adc_rise) begin
            err_q <= ERR_OVR;
          end else if (exp_rise) begin
            err_q <= ERR_NONE;
          end

          if (out_valid_q && out_if.Out_ready) begin
            if (is_last(idx)) begin
              state       <= IDLE;
              idx         <= 2'd0;
              out_data_q  <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              idx        <= idx + 2'd1;
              out_data_q <= pix[idx + 2'd1];
              out_last_q <= is_last(idx + 2'd1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign out_if.Out_data  = out_data_q;
  assign out_if.Out_addr  = idx;
  assign out_if.Out_valid = out_valid_q;
  assign out_if.Out_last  = out_last_q;

  assign Busy = (state != IDLE);
  assign Err  = err_q;

endmodule
